matrix_result_streamer: RTL and testbench

- Read-side companion to the combinational matrix subtractor.
- Captures one flattened signed result matrix (result_out), its matrix_size and its overflow flag, then streams the active elements one per beat over a valid/ready interface.
- Sits between the subtractor and any narrow consumer (UART or display formatter) that cannot take a full 200-bit result bus.

---
 rtl/matrix_result_streamer.sv | 81 ++++++++
 tb/tb_matrix_result_streamer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures one packed signed result matrix and streams its N*N elements one beat at a time.
// Define MATRIX_STREAM_COLMAJOR_EN to emit column-major instead of row-major.
module matrix_result_streamer #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_in,
  input  logic [1:0]                        matrix_size,
  input  logic                              overflow_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ELEM_W-1:0]                 out_data,
  output logic [2:0]                        out_row,
  output logic [2:0]                        out_col,
  output logic                              out_last,
  output logic                              busy,
  output logic                              ovf_flag
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;
  logic [0:0]                        r_state;
  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] r_buf;
  logic [1:0]                        r_size;
  logic [2:0]                        r_row, r_col;
  logic [2:0]                        w_n, w_max;
  logic [4:0]                        w_k;
  logic                              w_last;
  assign w_n    = {1'b0, r_size} + 3'd2;
  assign w_max  = w_n - 3'd1;
  // Stride is N, not MAX_DIM: the subtractor packs densely.
  assign w_k    = 5'(r_row) * 5'(w_n) + 5'(r_col);
  assign w_last = (r_row == w_max) && (r_col == w_max);
  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_STREAM);
  assign out_valid  = busy;
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign out_last   = busy && w_last;
  assign out_data   = busy ? r_buf[w_k*ELEM_W +: ELEM_W] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_size   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      ovf_flag <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (load_valid) begin
        r_state  <= S_STREAM;
        r_buf    <= matrix_in;
        r_size   <= matrix_size;
        ovf_flag <= overflow_in;
        r_row    <= '0;
        r_col    <= '0;
      end
    end else if (out_ready) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_row   <= '0;
        r_col   <= '0;
      end else begin
`ifdef MATRIX_STREAM_COLMAJOR_EN
        if (r_row == w_max) begin
          r_row <= '0;
          r_col <= r_col + 3'd1;
        end else r_row <= r_row + 3'd1;
`else
        if (r_col == w_max) begin
          r_col <= '0;
          r_row <= r_row + 3'd1;
        end else r_col <= r_col + 3'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_matrix_result_streamer;
  localparam int EW = 8;
  localparam int MD = 5;
  localparam int BW = EW*MD*MD;
  logic          clk = 0, rst = 1, load_valid = 0, overflow_in = 0, out_ready = 0;
  logic [1:0]    matrix_size = 0;
  logic [BW-1:0] matrix_in = '0;
  logic          load_ready, out_valid, out_last, busy, ovf_flag;
  logic [EW-1:0] out_data;
  logic [2:0]    out_row, out_col;
  matrix_result_streamer #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .matrix_in(matrix_in), .matrix_size(matrix_size), .overflow_in(overflow_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .ovf_flag(ovf_flag)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [EW-1:0] d;
    logic [2:0]    r;
    logic [2:0]    c;
    logic          l;
  } beat_t;
  beat_t sb[$];
  logic  exp_ovf = 0;
  int    total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Expected stream: visit every (r,c) of the N x N matrix in emission order.
  function automatic void push_exp(input logic [1:0] sz, input logic [BW-1:0] m);
    int n = int'(sz) + 2;
    beat_t b;
    for (int a = 0; a < n; a++)
      for (int z = 0; z < n; z++) begin
`ifdef MATRIX_STREAM_COLMAJOR_EN
        b.r = 3'(z);
        b.c = 3'(a);
`else
        b.r = 3'(a);
        b.c = 3'(z);
`endif
        b.d = m[(int'(b.r)*n + int'(b.c))*EW +: EW];
        b.l = (b.r == 3'(n-1)) && (b.c == 3'(n-1));
        sb.push_back(b);
      end
  endfunction
  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("out_data", 32'(out_data), 32'(sb[0].d));
      chk("out_row", 32'(out_row), 32'(sb[0].r));
      chk("out_col", 32'(out_col), 32'(sb[0].c));
      chk("out_last", 32'(out_last), 32'(sb[0].l));
      chk("busy", 32'(busy), 1);
      chk("load_ready_stream", 32'(load_ready), 0);
      chk("ovf_flag", 32'(ovf_flag), 32'(exp_ovf));
      if (out_valid && out_ready) void'(sb.pop_front());
    end
  end
  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 1 && cyc <= 3);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction
  // mode: 0 ready high, 1 three-cycle stall on beat 1, 2 random ready, 3 ready high plus a mid-stream load pulse
  task automatic do_load(input logic [1:0] sz, input logic [BW-1:0] m, input logic ov, input int mode);
    int n = int'(sz) + 2;
    int cnt = 0, lows = 0;
    logic timed_out = 0;
    chk("load_ready_idle", 32'(load_ready), 1);
    chk("valid_idle", 32'(out_valid), 0);
    chk("busy_idle", 32'(busy), 0);
    matrix_size = sz;
    matrix_in   = m;
    overflow_in = ov;
    load_valid  = 1;
    @(posedge clk);
    exp_ovf = ov;
    push_exp(sz, m);
    #1;
    load_valid  = 0;
    matrix_in   = ~m;
    overflow_in = ~ov;
    out_ready   = rdy(mode, 0);
    lows += int'(!out_ready);
    while (1) begin
      @(posedge clk);
      #1;
      cnt++;
      if (sb.size() == 0) break;
      if (cnt > 4*n*n + 20) begin
        chk("timeout", 0, 1);
        sb.delete();
        timed_out = 1;
        break;
      end
      if (mode == 3 && cnt == 5) begin
        load_valid  = 1;
        matrix_size = 2'b00;
        for (int i = 0; i < MD*MD; i++) matrix_in[i*EW +: EW] = EW'($urandom);
        overflow_in = ~ov;
      end
      if (cnt == 6) load_valid = 0;
      out_ready = rdy(mode, cnt);
      lows += int'(!out_ready);
    end
    if (!timed_out) chk("cycles", 32'(cnt), 32'(n*n + lows));
    chk("load_ready_after", 32'(load_ready), 1);
    chk("busy_after", 32'(busy), 0);
    chk("ovf_hold", 32'(ovf_flag), 32'(ov));
  endtask
  logic [BW-1:0] m;
  logic [EW-1:0] v3 [9] = '{8'h7F, 8'd90, 8'd30, 8'd20, 8'd15, 8'd8, 8'd4, 8'd5, 8'd10};
  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ovf", 32'(ovf_flag), 0);
    #11 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < MD*MD; i++) m[i*EW +: EW] = EW'($urandom);
    for (int i = 0; i < 4; i++) m[i*EW +: EW] = EW'(5*(i+1));
    do_load(2'b00, m, 1'b0, 0);
    do_load(2'b00, m, 1'b0, 1);
    for (int i = 0; i < 9; i++) m[i*EW +: EW] = v3[i];
    do_load(2'b01, m, 1'b1, 0);
    for (int i = 0; i < MD*MD; i++) m[i*EW +: EW] = 8'd10;
    do_load(2'b11, m, 1'b0, 3);
    for (int i = 0; i < MD*MD; i++) m[i*EW +: EW] = (i < 16) ? EW'(i) : 8'hFF;
    do_load(2'b10, m, 1'b1, 0);
    for (int i = 0; i < 9; i++) m[i*EW +: EW] = v3[i];
    matrix_size = 2'b01;
    matrix_in   = m;
    overflow_in = 1;
    load_valid  = 1;
    @(posedge clk);
    exp_ovf = 1;
    push_exp(2'b01, m);
    #1;
    load_valid = 0;
    out_ready  = 1;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_load_ready", 32'(load_ready), 1);
    chk("midrst_ovf", 32'(ovf_flag), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_last", 32'(out_last), 0);
    chk("midrst_busy", 32'(busy), 0);
    sb.delete();
    exp_ovf = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) m[i*EW +: EW] = EW'(5*(i+1));
    do_load(2'b00, m, 1'b0, 0);
    repeat (8) begin
      for (int i = 0; i < MD*MD; i++) m[i*EW +: EW] = EW'($urandom);
      do_load(2'($urandom_range(0, 3)), m, 1'($urandom), 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
